// File: rtl/data_mem_bridge_if.sv
// Word-wide memory bus between the data-memory bridge and the memory.
// The bridge drives a request and holds it until the memory returns bus_ack.
interface data_mem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_byte_en,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_byte_en,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Bridges single-cycle datapath loads/stores (B/H/W/D) onto a 32-bit
// request/ack memory bus. Stalls the core while the access is in flight.
// A doubleword takes two beats, with the low word first.
module data_mem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_read_en,
  input  logic        data_mem_write_en,
  input  logic [31:0] data_mem_addr,
  input  logic [63:0] data_mem_write_data,
  input  logic [2:0]  data_mem_width,
  output logic [63:0] data_mem_data_fetched,
  output logic        stall,
  output logic        misaligned,
  data_mem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_width;
  logic [63:0] r_wdata;
  logic        r_we;
  logic [31:0] r_beat0;
  logic [63:0] r_fetched;

  logic        w_valid;
  logic        w_misal;
  logic        w_accept;
  logic        w_final;
  logic        w_dword;
  logic [31:0] w_beat_addr;
  logic [31:0] w_beat_wdata;
  logic [3:0]  w_beat_en;
  logic [31:0] w_lane;
  logic [63:0] w_load;

  assign w_valid = data_mem_read_en | data_mem_write_en;
  // width 3'b111 has size bits 11 and is handled as a doubleword
  assign w_dword = (r_width[1:0] == 2'b11);
  assign data_mem_data_fetched = r_fetched;

  // Alignment of the incoming request against its access size
  always_comb begin
    case (data_mem_width[1:0])
      2'b00:   w_misal = 1'b0;
      2'b01:   w_misal = data_mem_addr[0];
      2'b10:   w_misal = |data_mem_addr[1:0];
      default: w_misal = |data_mem_addr[2:0];
    endcase
  end

  // Address, byte enables and lane-replicated store data for the current beat
  always_comb begin
    w_beat_addr = {r_addr[31:2], 2'b00} + ((r_state == BEAT1) ? 32'd4 : 32'd0);
    case (r_width[1:0])
      2'b00: begin
        w_beat_en    = 4'b0001 << r_addr[1:0];
        w_beat_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_beat_en    = 4'b0011 << r_addr[1:0];
        w_beat_wdata = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_beat_en    = 4'b1111;
        w_beat_wdata = r_wdata[31:0];
      end
      default: begin
        w_beat_en    = 4'b1111;
        w_beat_wdata = (r_state == BEAT1) ? r_wdata[63:32] : r_wdata[31:0];
      end
    endcase
  end

  // Lane selection and sign/zero extension of the returned read data
  always_comb begin
    w_lane = bus.bus_rdata >> {r_addr[1:0], 3'b000};
    case (r_width)
      3'b000:  w_load = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load = {56'd0, w_lane[7:0]};
      3'b101:  w_load = {48'd0, w_lane[15:0]};
      3'b110:  w_load = {32'd0, w_lane[31:0]};
      default: w_load = {bus.bus_rdata, r_beat0};
    endcase
  end

  // Next-state, stall/misaligned and bus request generation
  always_comb begin
    w_next          = r_state;
    stall           = 1'b0;
    misaligned      = 1'b0;
    w_accept        = 1'b0;
    w_final         = 1'b0;
    bus.bus_req     = 1'b0;
    bus.bus_we      = 1'b0;
    bus.bus_addr    = '0;
    bus.bus_wdata   = '0;
    bus.bus_byte_en = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          misaligned = w_misal;
          if (!w_misal) begin
            stall    = 1'b1;
            w_accept = 1'b1;
            w_next   = BEAT0;
          end
        end
      end
      BEAT0, BEAT1: begin
        stall           = 1'b1;
        bus.bus_req     = 1'b1;
        bus.bus_we      = r_we;
        bus.bus_addr    = w_beat_addr;
        bus.bus_wdata   = w_beat_wdata;
        bus.bus_byte_en = w_beat_en;
        if (bus.bus_ack) begin
          if (r_state == BEAT0 && w_dword) begin
            w_next = BEAT1;
          end else begin
            w_next  = DONE;
            w_final = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register, request latch, first-beat capture and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_width   <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_beat0   <= '0;
      r_fetched <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= data_mem_addr;
        r_width <= data_mem_width;
        r_wdata <= data_mem_write_data;
        r_we    <= data_mem_write_en;
      end
      if (r_state == BEAT0 && bus.bus_ack && w_dword) begin
        r_beat0 <= bus.bus_rdata;
      end
      if (w_final && !r_we) begin
        r_fetched <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed scenarios followed by random accesses,
// with the bench acting as a byte-addressed memory behind the bus and a
// separate reference memory predicting load results.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [2:0]  width;
  logic [63:0] fetched;
  logic        stall;
  logic        misaligned;

  always #5 clk = ~clk;

  data_mem_bridge_if bus ();

  data_mem_bridge dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_mem_read_en     (rd_en),
    .data_mem_write_en    (wr_en),
    .data_mem_addr        (addr),
    .data_mem_write_data  (wdata),
    .data_mem_width       (width),
    .data_mem_data_fetched(fetched),
    .stall                (stall),
    .misaligned           (misaligned),
    .bus                  (bus)
  );

  logic [7:0]  smem [0:1023];
  logic [7:0]  rmem [0:1023];
  logic [63:0] exp_fetched;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] v);
    for (int unsigned k = 0; k < 4; k++) begin
      smem[(a + k) % 1024] = v[8*k +: 8];
      rmem[(a + k) % 1024] = v[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    logic [31:0] w;
    for (int unsigned k = 0; k < 4; k++) w[8*k +: 8] = smem[(a + k) % 1024];
    return w;
  endfunction

  // One full access: IDLE presentation, beats with 'waits' wait states each, DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [63:0] wd, input logic [2:0] wid,
                        input int unsigned waits, input string tag);
    int unsigned size, nbeats, stalls;
    logic        valid, mis, ack;
    logic [63:0] ld;
    logic [31:0] wa, ewd;
    logic [3:0]  een;
    size  = 1 << wid[1:0];
    valid = rd | wr;
    mis   = valid && ((a % size) != 0);
    ld    = '0;
    for (int unsigned k = 0; k < size; k++) ld[8*k +: 8] = rmem[(a + k) % 1024];
    if (!wid[2]) begin
      case (size)
        1: ld = {{56{ld[7]}}, ld[7:0]};
        2: ld = {{48{ld[15]}}, ld[15:0]};
        4: ld = {{32{ld[31]}}, ld[31:0]};
        default: ;
      endcase
    end
    rd_en = rd; wr_en = wr; addr = a; wdata = wd; width = wid;
    #1;
    check({tag, "_idle_mis"}, misaligned, mis);
    check({tag, "_idle_stall"}, stall, valid && !mis);
    check({tag, "_idle_req"}, bus.bus_req, 1'b0);
    if (!valid || mis) begin
      @(posedge clk); #1;
      check({tag, "_noacc_req"}, bus.bus_req, 1'b0);
      check({tag, "_noacc_stall"}, stall, 1'b0);
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      check({tag, "_noacc_fetched"}, fetched, exp_fetched);
      return;
    end
    stalls = 1;
    nbeats = (size == 8) ? 2 : 1;
    for (int unsigned b = 0; b < nbeats; b++) begin
      wa = {a[31:2], 2'b00} + 4 * b;
      for (int unsigned i = 0; i < 4; i++) begin
        een[i] = ((wa + i) >= a) && ((wa + i) < (a + size));
        ewd[8*i +: 8] = wd[8*(((wa + i + 8) - a) % size) +: 8];
      end
      for (int unsigned w = 0; w <= waits; w++) begin
        @(posedge clk); #1;
        ack = (w == waits);
        bus.bus_ack   = ack;
        bus.bus_rdata = ack ? slave_word(wa) : $urandom;
        #1;
        if (stall === 1'b1) stalls++;
        check({tag, "_beat_req"}, bus.bus_req, 1'b1);
        check({tag, "_beat_addr"}, bus.bus_addr, wa);
        check({tag, "_beat_we"}, bus.bus_we, wr);
        check({tag, "_beat_en"}, bus.bus_byte_en, een);
        if (wr) check({tag, "_beat_wdata"}, bus.bus_wdata, ewd);
        if (ack && wr) begin
          for (int unsigned i = 0; i < 4; i++)
            if (bus.bus_byte_en[i]) smem[(wa + i) % 1024] = bus.bus_wdata[8*i +: 8];
        end
      end
    end
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    #1;
    if (wr) begin
      for (int unsigned k = 0; k < size; k++) rmem[(a + k) % 1024] = wd[8*k +: 8];
    end else begin
      exp_fetched = ld;
    end
    check({tag, "_done_stall"}, stall, 1'b0);
    check({tag, "_done_req"}, bus.bus_req, 1'b0);
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(1 + nbeats * (waits + 1)));
    check({tag, "_fetched"}, fetched, exp_fetched);
    // request still held during DONE must not start a new access
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    check({tag, "_after_req"}, bus.bus_req, 1'b0);
    check({tag, "_after_stall"}, stall, 1'b0);
  endtask

  initial begin
    int unsigned diff;
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 8'($urandom);
      rmem[i] = smem[i];
    end
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; width = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetched", fetched, 64'd0);
    check("rst_req", bus.bus_req, 1'b0);
    check("rst_we", bus.bus_we, 1'b0);
    check("rst_addr", bus.bus_addr, 32'd0);
    check("rst_wdata", bus.bus_wdata, 32'd0);
    check("rst_en", bus.bus_byte_en, 4'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_mis", misaligned, 1'b0);
    rst = 1'b0;
    exp_fetched = '0;
    @(posedge clk); #1;

    // LW with one wait state
    put_word(32'h100, 32'h8000_0001);
    access(1'b1, 1'b0, 32'h100, 64'd0, 3'b010, 1, "lw");
    check("lw_const", fetched, 64'hFFFF_FFFF_8000_0001);

    // LD, two beats
    put_word(32'h200, 32'h1111_2222);
    put_word(32'h204, 32'h3333_4444);
    access(1'b1, 1'b0, 32'h200, 64'd0, 3'b011, 0, "ld");
    check("ld_const", fetched, 64'h3333_4444_1111_2222);

    // SB to the top byte lane
    access(1'b0, 1'b1, 32'h103, 64'h0000_0000_0000_00AB, 3'b000, 0, "sb");
    check("sb_fetched_const", fetched, 64'h3333_4444_1111_2222);

    // LHU / LH of the upper half
    put_word(32'h100, 32'hF00D_0000);
    access(1'b1, 1'b0, 32'h102, 64'd0, 3'b101, 0, "lhu");
    check("lhu_const", fetched, 64'h0000_0000_0000_F00D);
    access(1'b1, 1'b0, 32'h102, 64'd0, 3'b001, 2, "lh");
    check("lh_const", fetched, 64'hFFFF_FFFF_FFFF_F00D);

    // misaligned LW
    access(1'b1, 1'b0, 32'h101, 64'd0, 3'b010, 0, "lw_mis");

    // read and write together is a store; read it back
    access(1'b1, 1'b1, 32'h180, 64'h0123_4567_89AB_CDEF, 3'b011, 1, "sd_both");
    access(1'b1, 1'b0, 32'h180, 64'd0, 3'b011, 0, "ld_back");
    check("ld_back_const", fetched, 64'h0123_4567_89AB_CDEF);

    // ack with no request outstanding is ignored
    bus.bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.bus_rdata = $urandom;
      @(posedge clk); #1;
      check("idle_ack_req", bus.bus_req, 1'b0);
      check("idle_ack_stall", stall, 1'b0);
      check("idle_ack_fetched", fetched, exp_fetched);
    end
    bus.bus_ack = 1'b0;

    // reset during BEAT1 of an LD
    rd_en = 1'b1; addr = 32'h200; width = 3'b011;
    @(posedge clk); #1;
    bus.bus_ack = 1'b1; bus.bus_rdata = 32'h5555_6666;
    #1;
    check("abort_b0_addr", bus.bus_addr, 32'h200);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    #1;
    check("abort_b1_addr", bus.bus_addr, 32'h204);
    check("abort_b1_req", bus.bus_req, 1'b1);
    rst = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    check("abort_req", bus.bus_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_fetched", fetched, 64'd0);
    check("abort_addr", bus.bus_addr, 32'd0);
    rst = 1'b0;
    exp_fetched = '0;
    @(posedge clk); #1;

    // random accesses
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  rw;
      logic [31:0] ra;
      int unsigned sel, sz;
      rw  = 3'($urandom_range(0, 6));
      sz  = 1 << rw[1:0];
      ra  = $urandom_range(0, 1015);
      if ($urandom_range(0, 4) != 0) ra = ra & ~(sz - 1);
      sel = $urandom_range(0, 4);
      access((sel == 0) || (sel == 2) || (sel == 3), (sel == 1) || (sel == 2), ra,
             {$urandom, $urandom}, rw, $urandom_range(0, 3), "rand");
    end

    diff = 0;
    for (int i = 0; i < 1024; i++) if (smem[i] !== rmem[i]) diff++;
    check("mem_contents", 64'(diff), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 The block SHALL have this port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have this port: rst  in  1  reset, synchronous and active-high.
REQ-003 The block SHALL have this port: data_mem_read_en  in  1  load request from the single-cycle datapath.
REQ-004 The block SHALL have this port: data_mem_write_en  in  1  store request from the datapath.
REQ-005 The block SHALL have this port: data_mem_addr  in  32  byte address.
REQ-006 The block SHALL have this port: data_mem_write_data  in  64  store data, taken from its least significant bytes.
REQ-007 The block SHALL have this port: data_mem_width  in  3  funct3 (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU).
REQ-008 The block SHALL have this port: data_mem_data_fetched  out  64  extended load result to the datapath.
REQ-009 The block SHALL have this port: stall  out  1  the core holds the PC and register-file write while this is 1.
REQ-010 The block SHALL have this port: misaligned  out  1  the current request is misaligned.
REQ-011 The block SHALL have these bus ports: bus_req out 1; bus_we out 1; bus_addr out 32 (word-aligned, bits [1:0]=00); bus_wdata out 32; bus_byte_en out 4; bus_ack in 1; bus_rdata in 32.

Function
REQ-012 The FSM SHALL use exactly these states: IDLE, BEAT0, BEAT1, DONE.
REQ-013 The request SHALL be valid when read_en or write_en is 1; if both are 1, it SHALL be a store.
REQ-014 Size SHALL be 1/2/4/8 bytes for width[1:0] = 00/01/10/11.
REQ-015 misaligned SHALL be asserted, combinationally in IDLE, for a valid request whose addr is not a multiple of its size.
REQ-016 A misaligned request SHALL cause no bus access, SHALL leave stall at 0, and SHALL leave data_mem_data_fetched unchanged.
REQ-017 In IDLE, an aligned valid request SHALL drive stall=1 combinationally, latch addr, width, wdata and direction, and move to BEAT0.
REQ-018 In BEAT0 and BEAT1, bus_req SHALL be 1, and bus_addr, bus_we, bus_wdata and bus_byte_en SHALL stay stable until the cycle in which bus_ack=1.
REQ-019 BEAT0 SHALL use {addr[31:2],2'b00}, then go to BEAT1 if size=8, otherwise to DONE, on bus_ack.
REQ-020 BEAT1 SHALL use the BEAT0 word address + 4 and move to DONE on bus_ack.
REQ-021 For a doubleword, the low 32 bits SHALL be transferred in BEAT0.
REQ-022 bus_byte_en SHALL be: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word/dword = 4'b1111.
REQ-023 Store data SHALL be lane-replicated: a byte x4, a half x2, a word as-is; a dword SHALL send wdata[31:0] then wdata[63:32].
REQ-024 Load data SHALL be selected by addr[1:0] lane, sign-extended for B/H/W and zero-extended for BU/HU/WU, with dword = {beat1, beat0}.
REQ-025 The load result SHALL be registered into data_mem_data_fetched on the final ack and held until the next completed load.
REQ-026 Stores SHALL NOT change data_mem_data_fetched.
REQ-027 In the BEAT states, stall SHALL be 1; in DONE, stall SHALL be 0 and bus_req SHALL be 0.
REQ-028 DONE SHALL go to IDLE unconditionally after one cycle; request inputs that are still asserted in DONE SHALL be ignored.
REQ-029 With immediate ack, latency SHALL be: W/H/B = 3 cycles (IDLE, BEAT0, DONE) and D = 4 cycles.
REQ-030 bus_ack SHALL be ignored while bus_req=0, and unbounded wait states SHALL be tolerated.

Reset
REQ-031 While rst=1 at a clock edge, the state SHALL go to IDLE, and data_mem_data_fetched, the latched request and all bus outputs SHALL go to 0.
REQ-032 After reset, stall and misaligned SHALL reflect only the combinational inputs in IDLE.
REQ-033 A reset asserted mid-transaction SHALL abort the transaction, with bus_req=0 from the next cycle; the partial beat result SHALL be discarded.

Verification
REQ-034 LW at addr 0x100 with bus_rdata=0x8000_0001 and ack in 2nd bus cycle -> fetched=0xFFFF_FFFF_8000_0001; stall=1 for 3 cycles, then 0 in DONE.
REQ-035 LD at 0x200 with beats 0x1111_2222 then 0x3333_4444 -> bus_addr 0x200 then 0x204; fetched=0x3333_4444_1111_2222.
REQ-036 SB at 0x103 with data 0xAB -> bus_we=1, byte_en=1000, bus_wdata=0xABAB_ABAB, addr 0x100; fetched unchanged.
REQ-037 LHU at 0x102 with rdata 0xF00D_0000 -> fetched=0x0000_0000_0000_F00D; the same access as LH -> 0xFFFF_FFFF_FFFF_F00D.
REQ-038 LW at 0x101 -> misaligned=1, stall=0, no bus_req.
REQ-039 rst asserted in BEAT1 of an LD -> next cycle IDLE, bus_req=0, fetched=0.
